// File: rtl/chip_bridge_tx.sv
// chip_bridge_tx: transmit half of the off-chip bridge.
// Per-channel input FIFOs, per-channel credit counters, round-robin flit
// arbitration and LSB-first serialisation of each flit into LINK_W beats.
// Optional feature macro: CHIP_BRIDGE_TX_PARITY_EN (registered beat parity).
module chip_bridge_tx #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned FLIT_W     = 64,
    parameter int unsigned LINK_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CREDITS    = 8
) (
    input  logic                          chip_clk,
    input  logic                          rst,
    input  logic [NUM_CH*FLIT_W-1:0]      network_out,
    input  logic [NUM_CH-1:0]             data_out_val,
    output logic [NUM_CH-1:0]             data_out_rdy,
    output logic [LINK_W-1:0]             intcnct_data_out,
    output logic [$clog2(NUM_CH+1)-1:0]   intcnct_channel_out,
    input  logic [NUM_CH-1:0]             intcnct_credit_back_out,
    output logic                          intcnct_parity_out,
    output logic                          credit_err
);

    localparam int unsigned BEATS  = FLIT_W / LINK_W;
    localparam int unsigned CH_W   = $clog2(NUM_CH + 1);
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W  = $clog2(CREDITS + 1);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    // FIFO storage and bookkeeping
    logic [FLIT_W-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [CNT_W-1:0]  count_nxt [NUM_CH];
    logic [CRD_W-1:0]  credit [NUM_CH];

    logic [NUM_CH-1:0] push_c;
    logic [NUM_CH-1:0] pop_c;
    logic [NUM_CH-1:0] elig_c;
    logic [IDX_W-1:0]  pick_c;
    logic              any_c;
    logic              grant_c;
    logic              last_beat_c;
    logic              ovf_c;
    logic [FLIT_W-1:0] head_c;
    logic [CH_W-1:0]   nxt_ch;
    logic [LINK_W-1:0] nxt_data;

    // Scheduler state
    state_t            state;
    logic [BEAT_W-1:0] beat_q;
    logic [FLIT_W-1:0] shift_q;
    logic [IDX_W-1:0]  last_q;

    assign push_c      = data_out_val & data_out_rdy;
    assign last_beat_c = (state == SEND) && (beat_q == BEAT_W'(BEATS - 1));
    assign grant_c     = any_c && ((state == IDLE) || last_beat_c);
    assign head_c      = mem[pick_c][rd_ptr[pick_c]];

    // Occupancy update, eligibility, pops and credit overflow detection
    always_comb begin
        ovf_c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_nxt[i] = count[i];
            if (push_c[i] && !pop_c[i]) begin
                count_nxt[i] = count[i] + CNT_W'(1);
            end else if (pop_c[i] && !push_c[i]) begin
                count_nxt[i] = count[i] - CNT_W'(1);
            end
            elig_c[i] = (count[i] != '0) && (credit[i] != '0);
            pop_c[i]  = grant_c && (pick_c == IDX_W'(i));
            if (intcnct_credit_back_out[i] && !pop_c[i] && (credit[i] == CRD_W'(CREDITS))) begin
                ovf_c = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last granted channel
    always_comb begin
        int unsigned idx;
        idx    = 0;
        pick_c = last_q;
        any_c  = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_c && elig_c[IDX_W'(idx)]) begin
                pick_c = IDX_W'(idx);
                any_c  = 1'b1;
            end
        end
    end

    // Next beat to drive on the link (zero when the link goes idle)
    always_comb begin
        nxt_ch   = '0;
        nxt_data = '0;
        if (grant_c) begin
            nxt_ch   = CH_W'(pick_c) + CH_W'(1);
            nxt_data = head_c[LINK_W-1:0];
        end else if ((state == SEND) && !last_beat_c) begin
            nxt_ch   = intcnct_channel_out;
            nxt_data = shift_q[LINK_W-1:0];
        end
    end

    // FIFO payload writes; storage needs no reset
    always_ff @(posedge chip_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_c[i]) begin
                mem[i][wr_ptr[i]] <= network_out[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge chip_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            data_out_rdy <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_c[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i]        <= count_nxt[i];
                data_out_rdy[i] <= (count_nxt[i] != CNT_W'(FIFO_DEPTH));
            end
        end
    end

    // Credit counters: grant spends, return refills, saturating at CREDITS
    always_ff @(posedge chip_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                credit[i] <= CRD_W'(CREDITS);
            end
            credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pop_c[i] && !intcnct_credit_back_out[i]) begin
                    credit[i] <= credit[i] - CRD_W'(1);
                end else if (!pop_c[i] && intcnct_credit_back_out[i] &&
                             (credit[i] != CRD_W'(CREDITS))) begin
                    credit[i] <= credit[i] + CRD_W'(1);
                end
            end
            if (ovf_c) begin
                credit_err <= 1'b1;
            end
        end
    end

    // Scheduler FSM and registered link outputs
    always_ff @(posedge chip_clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            beat_q              <= '0;
            shift_q             <= '0;
            last_q              <= IDX_W'(NUM_CH - 1);
            intcnct_channel_out <= '0;
            intcnct_data_out    <= '0;
        end else begin
            intcnct_channel_out <= nxt_ch;
            intcnct_data_out    <= nxt_data;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        state   <= SEND;
                        beat_q  <= '0;
                        shift_q <= head_c >> LINK_W;
                        last_q  <= pick_c;
                    end
                end
                SEND: begin
                    if (grant_c) begin
                        beat_q  <= '0;
                        shift_q <= head_c >> LINK_W;
                        last_q  <= pick_c;
                    end else if (last_beat_c) begin
                        state <= IDLE;
                    end else begin
                        beat_q  <= beat_q + BEAT_W'(1);
                        shift_q <= shift_q >> LINK_W;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHIP_BRIDGE_TX_PARITY_EN
    // Parity over channel tag and data, registered alongside the beat
    always_ff @(posedge chip_clk or posedge rst) begin
        if (rst) begin
            intcnct_parity_out <= 1'b0;
        end else begin
            intcnct_parity_out <= ^{nxt_ch, nxt_data};
        end
    end
`else
    assign intcnct_parity_out = 1'b0;
`endif

endmodule

// File: doc/chip_bridge_tx.md
# chip_bridge_tx

Parametrised transmit half of the off-chip bridge. Accepts flits from NUM_CH on-chip network channels and buffers each channel in its own FIFO. Serialises each flit into LINK_W-bit beats on the shared interconnect, tagged with a channel id. Per-channel credit counters, replenished by credit-return pulses from the far side, gate the sending; channels are arbitrated round-robin at flit granularity.

## Interface

Parameters:
- NUM_CH, 3: number of network channels; must be ≥1.
- FLIT_W, 64: flit width; must be an integer multiple of LINK_W.
- LINK_W, 32: interconnect beat width.
- FIFO_DEPTH, 4: per-channel input FIFO depth; must be a power of 2 and ≥2.
- CREDITS, 8: initial and maximum credits per channel, counted in flits.
- Derived: BEATS = FLIT_W/LINK_W; CH_W = $clog2(NUM_CH+1).

Ports:
- chip_clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- network_out, in, NUM_CH*FLIT_W: flit per channel; channel i occupies bits [i*FLIT_W +: FLIT_W].
- data_out_val, in, NUM_CH: per-channel flit valid.
- data_out_rdy, out, NUM_CH: per-channel FIFO not full.
- intcnct_data_out, out, LINK_W: current beat.
- intcnct_channel_out, out, CH_W: 0 = idle; i+1 = beat belongs to channel i.
- intcnct_credit_back_out, in, NUM_CH: one-cycle pulse per flit credit returned to channel i.
- intcnct_parity_out, out, 1: beat parity (see Configuration).
- credit_err, out, 1: sticky flag, set when a credit return would exceed CREDITS.

## Operation

**Input side**
- Channel i enqueues a flit on every edge where data_out_val[i] && data_out_rdy[i].
- data_out_rdy[i] = !full[i], derived from registered occupancy. Enqueue and dequeue in the same cycle at full is not allowed, because rdy is already low.

**Scheduler**
- Two-state FSM: IDLE, SEND.
- Channel i is eligible when its FIFO is non-empty and credit[i] > 0.
- Round-robin pointer: the search starts at (last granted + 1) mod NUM_CH. The pointer is reset to NUM_CH-1, so channel 0 has first priority after reset.
- A grant pops the FIFO head into the shift register, decrements credit[i], and loads beat 0 onto the outputs.
- Grant points:
  - In IDLE, any cycle with an eligible channel grants one.
  - In SEND, the cycle driving the last beat grants the next flit if a channel is eligible, so there is no idle bubble between flits. Otherwise the FSM returns to IDLE.
- Beats go LSB-first: beat k = flit[k*LINK_W +: LINK_W]. Beats of one flit are never interleaved with another channel's beats.
- When BEATS = 1, every cycle is a last beat.

**Credits**
- credit[i] is 0..CREDITS wide. Update rules:
  - grant only: decrement.
  - credit-return pulse only: increment.
  - both in the same cycle: unchanged.
- A return pulse while credit[i] = CREDITS with no simultaneous grant leaves credit[i] at CREDITS (saturates) and sets credit_err. credit_err clears only on rst.

**Reset**
- All outputs and state clear asynchronously:
  - intcnct_channel_out = 0, intcnct_data_out = 0, intcnct_parity_out = 0, data_out_rdy = all ones, credit_err = 0.
  - FIFOs emptied, credits = CREDITS, FSM = IDLE.
- A flit in flight is discarded; the far side recovers via its own reset.

## Timing

- All outputs are registered.
- Latency: a flit enqueued at edge E0 into an empty FIFO, with credit and an idle link, drives beat 0 from edge E1. Beat k is driven from edge E1+k.
- Sustained throughput is one beat per cycle while any channel is eligible.
- A credit pulse at edge E makes a zero-credit channel eligible for a grant at edge E+1.
- data_out_rdy deasserts the cycle after the enqueue that fills the FIFO. It reasserts the cycle after the pop.

## Configuration

- CHIP_BRIDGE_TX_PARITY_EN defined: intcnct_parity_out = XOR-reduction of {intcnct_channel_out, intcnct_data_out}, registered with the beat. Idle cycles therefore give parity 0.
- Not defined: intcnct_parity_out is tied to 0 and no parity logic is built.

## Test plan

1. **Single flit.** Defaults; after reset, send channel 1 flit 64'hAAAA_BBBB_CCCC_DDDD → two beats, 32'hCCCC_DDDD then 32'hAAAA_BBBB, channel_out = 2, from the edge after enqueue; channel_out then returns to 0.
2. **Round-robin.** All three FIFOs hold 2 flits each → beat pairs in channel order 0,1,2,0,1,2 with no idle cycle between flits.
3. **Credit exhaustion.** 10 flits queued on channel 0, no returns → exactly 8 flits sent, then idle. One credit_back pulse → the 9th flit starts 1 cycle later.
4. **Backpressure.** Channel 2 credits = 0; enqueue 4 flits → data_out_rdy[2] = 0 after the 4th enqueue and the 5th flit is held. One return pulse → rdy[2] = 1 one cycle after the pop.
5. **Credit overflow and mid-flit reset.** A return pulse at full credit sets credit_err = 1 and credit stays 8. Asserting rst in the middle of a flit forces channel_out = 0 and credit_err = 0 immediately; the next flit sent after reset is a fresh one.
6. **Parity.** With CHIP_BRIDGE_TX_PARITY_EN, beat 32'h0000_0001 on channel 1 → parity 0; beat 32'h0000_0003 on channel 1 → parity 1. Without the macro, parity stays 0 throughout.
